// File: rtl/left_barrel_shifter_x7_8b.sv
// left_barrel_shifter_x7_8b: funnel left shifter (0..7) of in with fill from cin, registered output.
// Three log stages shift the 24-bit {0, in, cin} concatenation by 1, 2 and 4.
module left_barrel_shifter_x7_8b #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] cin,
   input  logic [SHW-1:0]   sh,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] cout
);
   logic [3*WIDTH-1:0] st [SHW+1];
   logic [WIDTH-1:0]   out_d, out_q, cout_d, cout_q;
   logic               valid_q;
   // With sh=0 the middle word is in itself, so cin never reaches out.
   assign st[0] = {{WIDTH{1'b0}}, in, cin};
   for (genvar k = 0; k < SHW; k++) begin : g_stage
      assign st[k+1] = sh[k] ? st[k] << (1 << k) : st[k];
   end
   always_comb begin
      out_d  = in_valid ? st[SHW][2*WIDTH-1:WIDTH]   : out_q;
      cout_d = in_valid ? st[SHW][3*WIDTH-1:2*WIDTH] : cout_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q   <= '0;
         cout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         cout_q  <= cout_d;
         valid_q <= in_valid;
      end
   end
   assign out       = out_q;
   assign cout      = cout_q;
   assign out_valid = valid_q;
endmodule

// File: tb/tb_left_barrel_shifter_x7_8b.sv
// tb_left_barrel_shifter_x7_8b: directed vectors, hold/reset behaviour and a swept model check.
module tb_left_barrel_shifter_x7_8b;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in, cin, out, cout;
   logic [2:0] sh;
   logic       out_valid;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] cins [8] = '{8'h00, 8'hff, 8'h80, 8'h01, 8'haa, 8'h55, 8'h3c, 8'hc9};
   logic [15:0] m;

   left_barrel_shifter_x7_8b dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .cin(cin), .sh(sh),
      .out_valid(out_valid), .out(out), .cout(cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic [2:0] s, input logic [7:0] a, input logic [7:0] c);
      in_valid = v;
      sh       = s;
      in       = a;
      cin      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic vec(input string tag, input logic [2:0] s, input logic [7:0] a, input logic [7:0] c,
                      input logic [7:0] eo, input logic [7:0] ec);
      step(1'b1, s, a, c);
      chk({tag, " out"}, out, eo);
      chk({tag, " cout"}, cout, ec);
      chk({tag, " valid"}, {7'b0, out_valid}, 8'd1);
   endtask

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] c, input logic [2:0] s);
      logic [23:0] cat;
      cat = {8'b0, a, c} << s;
      return {cat[23:16], cat[15:8]};
   endfunction

   initial begin
      rst_n = 1'b0;
      step(1'b0, 3'd0, 8'h00, 8'h00);
      step(1'b0, 3'd0, 8'h00, 8'h00);
      chk("rst out", out, 8'h00);
      chk("rst cout", cout, 8'h00);
      chk("rst valid", {7'b0, out_valid}, 8'd0);
      rst_n = 1'b1;
      vec("sh0", 3'd0, 8'b01101011, 8'b01000101, 8'b01101011, 8'b00000000);
      vec("sh1", 3'd1, 8'b01011001, 8'b01110101, 8'b10110010, 8'b00000000);
      vec("sh2", 3'd2, 8'b01101011, 8'b10010101, 8'b10101110, 8'b00000001);
      vec("sh4", 3'd4, 8'b10010101, 8'b11001011, 8'b01011100, 8'b00001001);
      vec("sh6", 3'd6, 8'b10010110, 8'b01001001, 8'b10010010, 8'b00100101);
      vec("sh7", 3'd7, 8'b01001000, 8'b01100110, 8'b00110011, 8'b00100100);
      vec("sh5", 3'd5, 8'b01000101, 8'b10010101, 8'b10110010, 8'b00001000);
      vec("sh3", 3'd3, 8'b11111111, 8'b11100000, 8'b11111111, 8'b00000111);
      // sh=0 must not let an unknown cin leak into out
      vec("sh0 xcin", 3'd0, 8'b10100101, 8'bxxxxxxxx, 8'b10100101, 8'b00000000);
      step(1'b0, 3'd1, 8'hff, 8'hff);
      chk("idle valid", {7'b0, out_valid}, 8'd0);
      chk("idle out hold", out, 8'b10100101);
      chk("idle cout hold", cout, 8'b00000000);
      step(1'b0, 3'd7, 8'h00, 8'h00);
      chk("idle2 out hold", out, 8'b10100101);
      vec("b2b a", 3'd1, 8'b10000001, 8'b10000000, 8'b00000011, 8'b00000001);
      vec("b2b b", 3'd4, 8'b11110000, 8'b10100000, 8'b00001010, 8'b00001111);
      vec("b2b c", 3'd7, 8'b11111111, 8'b11111111, 8'b11111111, 8'b01111111);
      rst_n = 1'b0;
      step(1'b1, 3'd3, 8'hff, 8'hff);
      chk("midrst out", out, 8'h00);
      chk("midrst cout", cout, 8'h00);
      chk("midrst valid", {7'b0, out_valid}, 8'd0);
      rst_n = 1'b1;
      for (int s = 0; s < 8; s++)
         for (int a = 0; a < 256; a++)
            for (int j = 0; j < 8; j++) begin
               step(1'b1, s[2:0], a[7:0], cins[j]);
               m = model(a[7:0], cins[j], s[2:0]);
               chk("sweep out", out, m[7:0]);
               chk("sweep cout", cout, m[15:8]);
               chk("sweep valid", {7'b0, out_valid}, 8'd1);
            end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
